store_buffer: RTL and testbench

- Circular buffer of in-flight stores; the memory-side counterpart to the reorder buffer's store commit port (store_commit_valid / store_commit_ready / store_commit_hazard).
- Stores allocate an entry at issue and receive address/data from the AGU at execute.
- The ROB marks them committed in program order; committed stores then drain to the data memory port in order.
- Flags ordering hazards when a load was sent while an older store's address was still unknown and that store later resolves to the same word.

---
 rtl/store_buffer.sv | 129 ++++++++++++
 tb/tb_store_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// In-order store buffer: allocate at issue, fill at execute, commit from the ROB, drain to memory.
// Commit/drain handshakes take effect on the next clock; drain outputs hold while mem_write_ready is low.
module store_buffer #(
    parameter int XLEN           = 32,
    parameter int SB_INDEX_WIDTH = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_SB_valid,
    output logic                      issue_SB_ready,
    output logic [SB_INDEX_WIDTH-1:0] issue_SB_index,
    input  logic                      exec_SB_valid,
    input  logic [SB_INDEX_WIDTH-1:0] exec_SB_index,
    input  logic [XLEN-1:0]           exec_SB_address,
    input  logic [XLEN-1:0]           exec_SB_data,
    input  logic [XLEN/8-1:0]         exec_SB_byte_en,
    input  logic                      load_sent_valid,
    input  logic [XLEN-1:0]           load_sent_address,
    input  logic                      store_commit_valid,
    output logic                      store_commit_ready,
    output logic                      store_commit_hazard,
    output logic                      mem_write_valid,
    input  logic                      mem_write_ready,
    output logic [XLEN-1:0]           mem_write_address,
    output logic [XLEN-1:0]           mem_write_data,
    output logic [XLEN/8-1:0]         mem_write_byte_en,
    input  logic                      flush,
    output logic                      empty
);
    localparam int DEPTH = 2**SB_INDEX_WIDTH;
    localparam int CW    = SB_INDEX_WIDTH + 1;
    localparam int BW    = XLEN / 8;

    typedef logic [SB_INDEX_WIDTH-1:0] idx_t;
    typedef logic [CW-1:0]             cnt_t;
    typedef logic [XLEN-3:0]           word_t;
    typedef enum logic [1:0] {S_FREE, S_ALLOC, S_EXEC, S_COMMITTED} state_t;
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [BW-1:0]   byte_en;
    } payload_t;

    state_t   st        [DEPTH];
    payload_t pay       [DEPTH];
    logic     hazard    [DEPTH];
    logic     load_seen [DEPTH];
    word_t    load_word [DEPTH];

    idx_t tail, cptr, head;
    cnt_t count, committed_cnt;

    logic  issue_fire, commit_fire, drain_fire;
    word_t exec_word, load_word_in;
    logic  unused_load_lsb;

    assign exec_word       = exec_SB_address[XLEN-1:2];
    assign load_word_in    = load_sent_address[XLEN-1:2];
    assign unused_load_lsb = ^load_sent_address[1:0];

    assign issue_SB_ready      = (count != cnt_t'(DEPTH));
    assign issue_SB_index      = tail;
    assign store_commit_ready  = (st[cptr] == S_EXEC);
    assign store_commit_hazard = store_commit_ready & hazard[cptr];
    assign mem_write_valid     = (st[head] == S_COMMITTED);
    assign mem_write_address   = pay[head].addr;
    assign mem_write_data      = pay[head].data;
    assign mem_write_byte_en   = pay[head].byte_en;
    assign empty               = (count == '0);

    // A flushed issue never allocates, even though issue_SB_ready may be high.
    assign issue_fire  = issue_SB_valid && issue_SB_ready && !flush;
    assign commit_fire = store_commit_valid && store_commit_ready;
    assign drain_fire  = mem_write_valid && mem_write_ready;

    always_comb begin
        committed_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st[i] == S_COMMITTED) committed_cnt = committed_cnt + cnt_t'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            tail  <= '0;
            cptr  <= '0;
            head  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                st[i]        <= S_FREE;
                hazard[i]    <= 1'b0;
                load_seen[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (exec_SB_valid && exec_SB_index == idx_t'(i) && st[i] == S_ALLOC) begin
                    st[i]  <= S_EXEC;
                    pay[i] <= '{addr: exec_SB_address, data: exec_SB_data, byte_en: exec_SB_byte_en};
                    // An unrecorded load arriving this cycle counts as the first load seen.
                    hazard[i] <= load_seen[i] ? (load_word[i] == exec_word)
                                              : (load_sent_valid && load_word_in == exec_word);
                end
                if (load_sent_valid && st[i] == S_ALLOC && !load_seen[i]) begin
                    load_seen[i] <= 1'b1;
                    load_word[i] <= load_word_in;
                end
                if (issue_fire && tail == idx_t'(i)) begin
                    st[i]        <= S_ALLOC;
                    hazard[i]    <= 1'b0;
                    load_seen[i] <= 1'b0;
                end
                if (commit_fire && cptr == idx_t'(i)) st[i] <= S_COMMITTED;
                if (drain_fire && head == idx_t'(i)) st[i] <= S_FREE;
                if (flush && (st[i] == S_ALLOC || st[i] == S_EXEC) &&
                    !(commit_fire && cptr == idx_t'(i))) st[i] <= S_FREE;
            end

            cptr <= cptr + idx_t'(commit_fire);
            head <= head + idx_t'(drain_fire);
            if (flush) begin
                tail  <= cptr + idx_t'(commit_fire);
                count <= committed_cnt + cnt_t'(commit_fire) - cnt_t'(drain_fire);
            end else begin
                tail  <= tail + idx_t'(issue_fire);
                count <= count + cnt_t'(issue_fire) - cnt_t'(drain_fire);
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: ordering, full/wrap, hazard detection, flush and mid-drain reset.
module tb_store_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic        issue_SB_valid;
    logic        issue_SB_ready;
    logic [2:0]  issue_SB_index;
    logic        exec_SB_valid;
    logic [2:0]  exec_SB_index;
    logic [31:0] exec_SB_address;
    logic [31:0] exec_SB_data;
    logic [3:0]  exec_SB_byte_en;
    logic        load_sent_valid;
    logic [31:0] load_sent_address;
    logic        store_commit_valid;
    logic        store_commit_ready;
    logic        store_commit_hazard;
    logic        mem_write_valid;
    logic        mem_write_ready;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_byte_en;
    logic        flush;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    store_buffer #(.XLEN(32), .SB_INDEX_WIDTH(3)) dut (
        .clock(clock), .reset(reset),
        .issue_SB_valid(issue_SB_valid), .issue_SB_ready(issue_SB_ready), .issue_SB_index(issue_SB_index),
        .exec_SB_valid(exec_SB_valid), .exec_SB_index(exec_SB_index), .exec_SB_address(exec_SB_address),
        .exec_SB_data(exec_SB_data), .exec_SB_byte_en(exec_SB_byte_en),
        .load_sent_valid(load_sent_valid), .load_sent_address(load_sent_address),
        .store_commit_valid(store_commit_valid), .store_commit_ready(store_commit_ready),
        .store_commit_hazard(store_commit_hazard),
        .mem_write_valid(mem_write_valid), .mem_write_ready(mem_write_ready),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_write_byte_en(mem_write_byte_en),
        .flush(flush), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue_SB_valid     = 1'b0;
        exec_SB_valid      = 1'b0;
        exec_SB_index      = '0;
        exec_SB_address    = '0;
        exec_SB_data       = '0;
        exec_SB_byte_en    = '0;
        load_sent_valid    = 1'b0;
        load_sent_address  = '0;
        store_commit_valid = 1'b0;
        mem_write_ready    = 1'b0;
        flush              = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic issue_one();
        issue_SB_valid = 1'b1;
        tick();
        issue_SB_valid = 1'b0;
    endtask

    task automatic exec_store(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
        exec_SB_valid   = 1'b1;
        exec_SB_index   = idx;
        exec_SB_address = a;
        exec_SB_data    = d;
        exec_SB_byte_en = 4'hF;
        tick();
        exec_SB_valid   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (issue_SB_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%b exp=1", issue_SB_ready); end
        checks++; if (issue_SB_index !== 3'd0) begin failures++; $display("FAIL reset_issue_index got=%0d exp=0", issue_SB_index); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (mem_write_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_write_valid); end
        checks++; if (store_commit_ready !== 1'b0) begin failures++; $display("FAIL reset_commit_ready got=%b exp=0", store_commit_ready); end
        checks++; if (store_commit_hazard !== 1'b0) begin failures++; $display("FAIL reset_commit_hazard got=%b exp=0", store_commit_hazard); end
        reset = 1'b1;
    endtask

    task automatic test_in_order();
        do_reset();
        issue_SB_valid = 1'b1;
        tick(); tick(); tick();
        issue_SB_valid = 1'b0;
        checks++; if (issue_SB_index !== 3'd3) begin failures++; $display("FAIL order_tail got=%0d exp=3", issue_SB_index); end
        exec_store(3'd1, 32'h104, 32'hB);
        checks++; if (store_commit_ready !== 1'b0) begin failures++; $display("FAIL order_ready_early got=%b exp=0", store_commit_ready); end
        exec_store(3'd0, 32'h100, 32'hA);
        checks++; if (store_commit_ready !== 1'b1) begin failures++; $display("FAIL order_ready_after_exec0 got=%b exp=1", store_commit_ready); end
        mem_write_ready    = 1'b1;
        store_commit_valid = 1'b1;
        tick();
        checks++; if (mem_write_valid !== 1'b1 || mem_write_address !== 32'h100 || mem_write_data !== 32'hA)
            begin failures++; $display("FAIL order_write0 got=%b/%h/%h exp=1/00000100/0000000a", mem_write_valid, mem_write_address, mem_write_data); end
        tick();
        store_commit_valid = 1'b0;
        checks++; if (mem_write_valid !== 1'b1 || mem_write_address !== 32'h104 || mem_write_data !== 32'hB)
            begin failures++; $display("FAIL order_write1 got=%b/%h/%h exp=1/00000104/0000000b", mem_write_valid, mem_write_address, mem_write_data); end
        checks++; if (store_commit_ready !== 1'b0) begin failures++; $display("FAIL order_idx2_not_ready got=%b exp=0", store_commit_ready); end
        tick();
        checks++; if (mem_write_valid !== 1'b0 || empty !== 1'b0)
            begin failures++; $display("FAIL order_idx2_remains got valid=%b empty=%b exp valid=0 empty=0", mem_write_valid, empty); end
        mem_write_ready = 1'b0;
    endtask

    task automatic test_full_wrap();
        int writes;
        do_reset();
        issue_SB_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (issue_SB_ready !== 1'b0 || issue_SB_index !== 3'd0)
            begin failures++; $display("FAIL full_after8 got ready=%b idx=%0d exp ready=0 idx=0", issue_SB_ready, issue_SB_index); end
        tick();
        issue_SB_valid = 1'b0;
        checks++; if (issue_SB_ready !== 1'b0 || issue_SB_index !== 3'd0)
            begin failures++; $display("FAIL full_ninth_ignored got ready=%b idx=%0d exp ready=0 idx=0", issue_SB_ready, issue_SB_index); end
        for (int i = 0; i < 8; i++) exec_store(3'(i), 32'h1000 + 32'(4 * i), 32'h50 + 32'(i));
        store_commit_valid = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        store_commit_valid = 1'b0;
        checks++; if (store_commit_ready !== 1'b0) begin failures++; $display("FAIL full_all_committed got=%b exp=0", store_commit_ready); end
        mem_write_ready = 1'b1;
        writes = 0;
        for (int c = 0; c < 20 && writes < 8; c++) begin
            if (mem_write_valid === 1'b1) begin
                checks++;
                if (mem_write_address !== 32'h1000 + 32'(4 * writes) || mem_write_data !== 32'h50 + 32'(writes))
                    begin failures++; $display("FAIL full_write%0d got=%h/%h exp=%h/%h", writes, mem_write_address, mem_write_data, 32'h1000 + 32'(4 * writes), 32'h50 + 32'(writes)); end
                writes++;
            end
            tick();
        end
        checks++; if (writes != 8) begin failures++; $display("FAIL full_write_count got=%0d exp=8", writes); end
        checks++; if (empty !== 1'b1 || issue_SB_ready !== 1'b1)
            begin failures++; $display("FAIL full_drained got empty=%b ready=%b exp 1/1", empty, issue_SB_ready); end
        mem_write_ready = 1'b0;
    endtask

    task automatic test_hazard();
        do_reset();
        issue_one();
        load_sent_valid = 1'b1; load_sent_address = 32'h200;
        tick();
        load_sent_valid = 1'b0;
        exec_store(3'd0, 32'h202, 32'h1);
        checks++; if (store_commit_ready !== 1'b1 || store_commit_hazard !== 1'b1)
            begin failures++; $display("FAIL hazard_same_word got ready=%b hz=%b exp 1/1", store_commit_ready, store_commit_hazard); end

        do_reset();
        issue_one();
        load_sent_valid = 1'b1; load_sent_address = 32'h200;
        tick();
        load_sent_valid = 1'b0;
        exec_store(3'd0, 32'h204, 32'h1);
        checks++; if (store_commit_ready !== 1'b1 || store_commit_hazard !== 1'b0)
            begin failures++; $display("FAIL hazard_other_word got ready=%b hz=%b exp 1/0", store_commit_ready, store_commit_hazard); end

        do_reset();
        issue_one();
        load_sent_valid = 1'b1; load_sent_address = 32'h301;
        exec_store(3'd0, 32'h300, 32'h2);
        load_sent_valid = 1'b0;
        checks++; if (store_commit_hazard !== 1'b1)
            begin failures++; $display("FAIL hazard_same_cycle got=%b exp=1", store_commit_hazard); end
    endtask

    task automatic test_flush();
        int writes;
        do_reset();
        issue_SB_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        issue_SB_valid = 1'b0;
        for (int i = 0; i < 4; i++) exec_store(3'(i), 32'h400 + 32'(4 * i), 32'hC0 + 32'(i));
        store_commit_valid = 1'b1;
        tick(); tick();
        store_commit_valid = 1'b0;
        flush = 1'b1;
        issue_SB_valid = 1'b1;
        tick();
        flush = 1'b0;
        issue_SB_valid = 1'b0;
        checks++; if (issue_SB_index !== 3'd2) begin failures++; $display("FAIL flush_tail got=%0d exp=2", issue_SB_index); end
        checks++; if (store_commit_ready !== 1'b0 || empty !== 1'b0 || mem_write_valid !== 1'b1)
            begin failures++; $display("FAIL flush_state got cr=%b empty=%b mv=%b exp 0/0/1", store_commit_ready, empty, mem_write_valid); end
        mem_write_ready = 1'b1;
        writes = 0;
        for (int c = 0; c < 6; c++) begin
            if (mem_write_valid === 1'b1) writes++;
            tick();
        end
        mem_write_ready = 1'b0;
        checks++; if (writes != 2) begin failures++; $display("FAIL flush_write_count got=%0d exp=2", writes); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", empty); end
        issue_one();
        checks++; if (issue_SB_index !== 3'd3 || empty !== 1'b0)
            begin failures++; $display("FAIL flush_next_issue got idx=%0d empty=%b exp 3/0", issue_SB_index, empty); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        issue_one();
        exec_store(3'd0, 32'h500, 32'hD);
        store_commit_valid = 1'b1;
        tick();
        store_commit_valid = 1'b0;
        tick();
        checks++; if (mem_write_valid !== 1'b1 || mem_write_address !== 32'h500)
            begin failures++; $display("FAIL middrain_hold got=%b/%h exp=1/00000500", mem_write_valid, mem_write_address); end
        reset = 1'b0;
        issue_SB_valid = 1'b1;
        tick();
        reset = 1'b1;
        issue_SB_valid = 1'b0;
        checks++; if (mem_write_valid !== 1'b0 || empty !== 1'b1 || issue_SB_index !== 3'd0)
            begin failures++; $display("FAIL middrain_reset got mv=%b empty=%b idx=%0d exp 0/1/0", mem_write_valid, empty, issue_SB_index); end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_hazard();
        test_flush();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
